pe_array_os: RTL and testbench
==============================

# pe_array_os

Parametrised output-stationary systolic MAC array, successor to the broadcast PE grid. Activation vectors enter from the west and weight vectors from the north, each with an internal per-lane skew. Every cell accumulates a private partial sum over a K-deep pass, and the array then drains its results column by column through a ready/valid port toward the SFU/output SRAM. It sits between the L0/IFIFO feeders and the output buffer.

## Interface
- BW, 8, activation/weight width (signed two's complement)
- PSUM_BW, 20, accumulator width; must be ≥ 2*BW
- ROW, 4, array rows = activation lanes
- COL, 4, array columns = weight lanes
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  act_in/wgt_in/in_last beat valid
- in_ready  out  1  array accepts a beat; reset 0
- in_last  in  1  final beat of the K-deep pass
- act_in  in  ROW*BW  activation vector, lane i at [i*BW +: BW]
- wgt_in  in  COL*BW  weight vector, lane j at [j*BW +: BW]
- out_valid  out  1  drain beat valid; reset 0
- out_ready  in  1  downstream accepts drain beat
- out_data  out  ROW*PSUM_BW  one column of psums, row i at [i*PSUM_BW +: PSUM_BW]; reset 0
- out_col  out  $clog2(COL)  column index of the current beat; reset 0
- out_last  out  1  final drain beat (column COL-1); reset 0
- busy  out  1  state ≠ IDLE; reset 0
- ovf  out  1  sticky accumulator overflow for the current pass; reset 0

## Operation
- FSM states:
  - IDLE: in_ready=1; the first accepted beat clears all accumulators and ovf, then enters LOAD (or FLUSH if in_last).
  - LOAD: in_ready=1; accepting a beat with in_last → FLUSH.
  - FLUSH: in_ready=0; counter runs ROW+COL-1 cycles, then → DRAIN.
  - DRAIN: in_ready=0; out_valid=1; col counter advances on out_valid&out_ready; the out_last handshake → IDLE.
- Beat acceptance: in_valid & in_ready.
- Skew: activation lane i passes through i register stages; weight lane j passes through j stages. Each stage carries a valid bit alongside the data.
- Inter-cell flow: activation travels east and weight travels south, with one register per cell hop.
- Accumulation: cell (i,j) accumulates only when both operand valid bits are set. Bubbles (in_valid=0 during LOAD) propagate as invalid and never add.
- Arithmetic: signed product is 2*BW bits, sign-extended to PSUM_BW, added into acc[i][j].
- Overflow: signed overflow on any add sets ovf, which stays set until the next pass start.
- Drain: out_data is a registered mux of acc[*][out_col]. Accumulators are not modified during DRAIN.
- Reset mid-operation: all state, skews, accumulators and outputs return to reset values immediately. No partial drain occurs.

## Timing
- Input: zero-bubble acceptance, one beat per cycle, in IDLE/LOAD.
- Cell update: operand pair k reaches cell (i,j) and updates its accumulator i+j+1 cycles after the edge that accepted beat k.
- Drain start: out_valid rises exactly ROW+COL cycles after the edge accepting in_last (4×4: 8 cycles).
- Drain throughput: one column per cycle under continuous out_ready; minimum COL cycles.
- Backpressure: while out_valid&!out_ready, out_data, out_col and out_last hold stable.
- Return to IDLE: in_ready reasserts the cycle after the out_last handshake, so the next pass can begin immediately.
- K=1 (in_valid&in_last in IDLE): legal; goes straight to FLUSH.
- in_last is ignored when in_valid=0.

## Configuration
- PE_ARRAY_SAT_EN defined:
  - on overflow, the accumulator clamps to +2^(PSUM_BW-1)-1 or -2^(PSUM_BW-1), and ovf is set.
  - subsequent adds continue from the clamped value.
- Undefined:
  - accumulator wraps modulo 2^PSUM_BW; ovf is still set.

## Test plan
- 4×4, K=1, all act=1, all wgt=2, out_ready=1 → out_valid at +8 cycles; 4 beats, every psum=2; out_last on col 3; in_ready high the next cycle.
- 4×4, K=4, act[k]=identity row k, wgt[k][j]=j+1+4k → column j, row i = i*4+j+1; out_col sequence 0,1,2,3.
- Same as the K=4 case, with in_valid toggling 1-0-1-0 during LOAD → results identical to the gap-free run; out_valid rises 8 cycles after in_last.
- Drain with out_ready low for 3 cycles on col 1 → out_data/out_col held stable; total drain 7 cycles; no beat lost or duplicated.
- BW=8, PSUM_BW=16, K=3, act=-128, wgt=-128 (product 16384): sum 49152 overflows.
  - With PE_ARRAY_SAT_EN: psum=32767, ovf=1.
  - Without: psum=-16384, ovf=1.
  - Next pass clears ovf.
- Assert reset (low) mid-FLUSH → all outputs 0 asynchronously. After release: IDLE, in_ready=1, and a fresh pass yields correct sums with no residue.

Source files
------------

// File: rtl/pe_array_os.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_os
// Brief    : Output-stationary ROW x COL systolic MAC array. Skewed west
//            activation and north weight feeds, per-cell private accumulators,
//            column-serial ready/valid drain. Optional macro PE_ARRAY_SAT_EN
//            selects saturating accumulators (default: wrap-around).
// Revision : 1.0 - initial release
// ============================================================================
module pe_array_os #(
    parameter int BW      = 8,
    parameter int PSUM_BW = 20,
    parameter int ROW     = 4,
    parameter int COL     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [ROW*BW-1:0]        act_in,
    input  logic [COL*BW-1:0]        wgt_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW*PSUM_BW-1:0]   out_data,
    output logic [$clog2(COL)-1:0]   out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     ovf
);

    localparam int c_CW = $clog2(COL);
    localparam int c_FW = $clog2(ROW + COL) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'(ROW + COL - 2);
    localparam logic [c_CW-1:0] c_COL_LAST   = c_CW'(COL - 1);

`ifdef PE_ARRAY_SAT_EN
    localparam logic signed [PSUM_BW-1:0] c_PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [PSUM_BW-1:0] c_PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};
`endif

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      r_in_ready;
    logic                      w_accept;
    logic                      w_start;
    logic [c_FW-1:0]           r_flush_cnt;

    logic signed [BW-1:0]      w_a_west  [ROW];
    logic                      w_av_west [ROW];
    logic signed [BW-1:0]      w_w_north [COL];
    logic                      w_wv_north[COL];

    logic signed [BW-1:0]      r_a     [ROW][COL];
    logic signed [BW-1:0]      r_w     [ROW][COL];
    logic                      r_av    [ROW][COL];
    logic                      r_wv    [ROW][COL];
    logic signed [BW-1:0]      w_a_in  [ROW][COL];
    logic signed [BW-1:0]      w_w_in  [ROW][COL];
    logic                      w_av_in [ROW][COL];
    logic                      w_wv_in [ROW][COL];

    logic signed [2*BW-1:0]    w_prod    [ROW][COL];
    logic signed [PSUM_BW-1:0] w_ext     [ROW][COL];
    logic signed [PSUM_BW-1:0] w_sum     [ROW][COL];
    logic                      w_add_ovf [ROW][COL];
    logic signed [PSUM_BW-1:0] w_acc_nxt [ROW][COL];
    logic signed [PSUM_BW-1:0] r_acc     [ROW][COL];
    logic                      w_any_ovf;
    logic                      r_ovf;

    logic [c_CW-1:0]           r_rd_col;
    logic                      r_rd_done;
    logic [ROW*PSUM_BW-1:0]    w_col_data;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic [c_CW-1:0]           r_out_col;
    logic [ROW*PSUM_BW-1:0]    r_out_data;

    assign w_accept = in_valid & r_in_ready;
    assign w_start  = w_accept & (r_state == c_IDLE);

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = in_last ? c_FLUSH : c_LOAD;
            c_LOAD:  if (w_accept && in_last) w_state_nxt = c_FLUSH;
            c_FLUSH: if (r_flush_cnt == c_FLUSH_LAST) w_state_nxt = c_DRAIN;
            c_DRAIN: if (r_out_valid && out_ready && r_out_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_in_ready  <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == c_IDLE) || (w_state_nxt == c_LOAD);
            r_flush_cnt <= (r_state == c_FLUSH) ? r_flush_cnt + c_FW'(1) : '0;
        end
    end

    // ------------------------------------------------------- operand skew
    // Lane n is delayed n cycles so that beat k meets at cell (i,j) together.
    for (genvar gi = 0; gi < ROW; gi++) begin : g_act_skew
        if (gi == 0) begin : g_direct
            assign w_a_west[gi]  = act_in[gi*BW +: BW];
            assign w_av_west[gi] = w_accept;
        end else begin : g_stages
            logic signed [BW-1:0] r_d [gi];
            logic                 r_v [gi];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < gi; s++) begin
                        r_d[s] <= '0;
                        r_v[s] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= act_in[gi*BW +: BW];
                    r_v[0] <= w_accept;
                    for (int s = 1; s < gi; s++) begin
                        r_d[s] <= r_d[s-1];
                        r_v[s] <= r_v[s-1];
                    end
                end
            end
            assign w_a_west[gi]  = r_d[gi-1];
            assign w_av_west[gi] = r_v[gi-1];
        end
    end

    for (genvar gj = 0; gj < COL; gj++) begin : g_wgt_skew
        if (gj == 0) begin : g_direct
            assign w_w_north[gj]  = wgt_in[gj*BW +: BW];
            assign w_wv_north[gj] = w_accept;
        end else begin : g_stages
            logic signed [BW-1:0] r_d [gj];
            logic                 r_v [gj];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < gj; s++) begin
                        r_d[s] <= '0;
                        r_v[s] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= wgt_in[gj*BW +: BW];
                    r_v[0] <= w_accept;
                    for (int s = 1; s < gj; s++) begin
                        r_d[s] <= r_d[s-1];
                        r_v[s] <= r_v[s-1];
                    end
                end
            end
            assign w_w_north[gj]  = r_d[gj-1];
            assign w_wv_north[gj] = r_v[gj-1];
        end
    end

    // --------------------------------------------------------- cell array
    always_comb begin
        for (int i = 0; i < ROW; i++) begin
            w_a_in[i][0]  = w_a_west[i];
            w_av_in[i][0] = w_av_west[i];
            for (int j = 1; j < COL; j++) begin
                w_a_in[i][j]  = r_a[i][j-1];
                w_av_in[i][j] = r_av[i][j-1];
            end
        end
        for (int j = 0; j < COL; j++) begin
            w_w_in[0][j]  = w_w_north[j];
            w_wv_in[0][j] = w_wv_north[j];
            for (int i = 1; i < ROW; i++) begin
                w_w_in[i][j]  = r_w[i-1][j];
                w_wv_in[i][j] = r_wv[i-1][j];
            end
        end
    end

    always_comb begin
        w_any_ovf = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            for (int j = 0; j < COL; j++) begin
                w_prod[i][j]    = (2*BW)'(r_a[i][j]) * (2*BW)'(r_w[i][j]);
                w_ext[i][j]     = PSUM_BW'(w_prod[i][j]);
                w_sum[i][j]     = r_acc[i][j] + w_ext[i][j];
                // Same-sign operands producing an opposite-sign sum is signed overflow.
                w_add_ovf[i][j] = (r_acc[i][j][PSUM_BW-1] == w_ext[i][j][PSUM_BW-1]) &&
                                  (w_sum[i][j][PSUM_BW-1] != r_acc[i][j][PSUM_BW-1]);
                w_acc_nxt[i][j] = w_sum[i][j];
`ifdef PE_ARRAY_SAT_EN
                if (w_add_ovf[i][j])
                    w_acc_nxt[i][j] = r_acc[i][j][PSUM_BW-1] ? c_PSUM_MIN : c_PSUM_MAX;
`endif
                if (r_av[i][j] && r_wv[i][j] && w_add_ovf[i][j])
                    w_any_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROW; i++) begin
                for (int j = 0; j < COL; j++) begin
                    r_a[i][j]   <= '0;
                    r_w[i][j]   <= '0;
                    r_av[i][j]  <= 1'b0;
                    r_wv[i][j]  <= 1'b0;
                    r_acc[i][j] <= '0;
                end
            end
            r_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < ROW; i++) begin
                for (int j = 0; j < COL; j++) begin
                    r_a[i][j]  <= w_a_in[i][j];
                    r_w[i][j]  <= w_w_in[i][j];
                    r_av[i][j] <= w_av_in[i][j];
                    r_wv[i][j] <= w_wv_in[i][j];
                    if (w_start)
                        r_acc[i][j] <= '0;
                    else if (r_av[i][j] && r_wv[i][j])
                        r_acc[i][j] <= w_acc_nxt[i][j];
                end
            end
            if (w_start)
                r_ovf <= 1'b0;
            else if (w_any_ovf)
                r_ovf <= 1'b1;
        end
    end

    // -------------------------------------------------------------- drain
    always_comb begin
        w_col_data = '0;
        for (int i = 0; i < ROW; i++)
            w_col_data[i*PSUM_BW +: PSUM_BW] = r_acc[i][r_rd_col];
    end

    // First DRAIN cycle only primes the output register, so the final
    // accumulator update from FLUSH is always captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_col    <= '0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_col   <= '0;
            r_out_data  <= '0;
        end else if (r_state != c_DRAIN) begin
            r_rd_col    <= '0;
            r_rd_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (!r_rd_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_col_data;
                r_out_col   <= r_rd_col;
                r_out_last  <= (r_rd_col == c_COL_LAST);
                if (r_rd_col == c_COL_LAST)
                    r_rd_done <= 1'b1;
                else
                    r_rd_col  <= r_rd_col + c_CW'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_col   = r_out_col;
    assign out_last  = r_out_last;
    assign busy      = (r_state != c_IDLE);
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_array_os
// Brief    : Self-checking bench for pe_array_os (4x4, BW=8, PSUM_BW=16)
//            against an integer-arithmetic matrix-product reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_array_os;

    localparam int BW      = 8;
    localparam int PSUM_BW = 16;
    localparam int ROW     = 4;
    localparam int COL     = 4;
    localparam int MAX_K   = 16;
    localparam int c_PMAX  = (2 ** (PSUM_BW - 1)) - 1;
    localparam int c_PMIN  = -(2 ** (PSUM_BW - 1));

    logic                   clk       = 1'b0;
    logic                   rst_n     = 1'b0;
    logic                   in_valid  = 1'b0;
    logic                   in_last   = 1'b0;
    logic                   out_ready = 1'b1;
    logic [ROW*BW-1:0]      act_in    = '0;
    logic [COL*BW-1:0]      wgt_in    = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic [ROW*PSUM_BW-1:0] out_data;
    logic [$clog2(COL)-1:0] out_col;
    logic                   out_last;
    logic                   busy;
    logic                   ovf;

    pe_array_os #(.BW(BW), .PSUM_BW(PSUM_BW), .ROW(ROW), .COL(COL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .act_in(act_in), .wgt_in(wgt_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int act_m [MAX_K][ROW];
    int wgt_m [MAX_K][COL];
    int exp_ps[ROW][COL];
    bit exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Plain matrix product, with range handling applied after every add.
    task automatic model(input int k_len);
        int acc;
        exp_ovf = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            for (int j = 0; j < COL; j++) begin
                acc = 0;
                for (int k = 0; k < k_len; k++) begin
                    acc = acc + act_m[k][i] * wgt_m[k][j];
                    if (acc > c_PMAX || acc < c_PMIN) begin
                        exp_ovf = 1'b1;
`ifdef PE_ARRAY_SAT_EN
                        acc = (acc > c_PMAX) ? c_PMAX : c_PMIN;
`else
                        acc = (acc > c_PMAX) ? acc - (2 ** PSUM_BW) : acc + (2 ** PSUM_BW);
`endif
                    end
                end
                exp_ps[i][j] = acc;
            end
        end
    endtask

    task automatic fill_rand(input int k_len, input int lo, input int hi);
        for (int k = 0; k < k_len; k++) begin
            for (int i = 0; i < ROW; i++) act_m[k][i] = lo + int'($urandom_range(0, hi - lo));
            for (int j = 0; j < COL; j++) wgt_m[k][j] = lo + int'($urandom_range(0, hi - lo));
        end
    endtask

    // gap_mode: 0 = back-to-back, 1 = alternate bubbles, 2 = random bubbles
    task automatic send_beats(input int k_len, input int gap_mode);
        for (int k = 0; k < k_len; k++) begin
            if (k > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
                in_valid = 1'b0;
                act_in   = $urandom;
                wgt_in   = $urandom;
                in_last  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_last  = (k == k_len - 1);
            for (int i = 0; i < ROW; i++) act_in[i*BW +: BW] = act_m[k][i][BW-1:0];
            for (int j = 0; j < COL; j++) wgt_in[j*BW +: BW] = wgt_m[k][j][BW-1:0];
            chk("in_ready_load", in_ready, 1);
            @(negedge clk);
            if (k == 0) chk("ovf_clear_at_start", ovf, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_pass(input int stall_col, input int stall_n);
        int m;
        int cycles;
        int col_exp;
        int stalls;
        int guard;
        logic [PSUM_BW-1:0] ev;
        logic [PSUM_BW-1:0] ov;
        chk("in_ready_flush", in_ready, 0);
        chk("busy_flush", busy, 1);
        m = 0;
        while (!out_valid && m < 64) begin
            @(negedge clk);
            m++;
        end
        chk("drain_latency", m, ROW + COL);
        chk("ovf", ovf, exp_ovf);
        col_exp = 0;
        stalls  = (stall_col >= 0) ? stall_n : 0;
        cycles  = 0;
        guard   = 0;
        while (col_exp < COL && guard < 64) begin
            chk("drain_valid", out_valid, 1);
            cycles++;
            chk("out_col", out_col, col_exp);
            chk("out_last", out_last, (col_exp == COL - 1));
            for (int i = 0; i < ROW; i++) begin
                ev = exp_ps[i][col_exp][PSUM_BW-1:0];
                ov = out_data[i*PSUM_BW +: PSUM_BW];
                chk($sformatf("psum r%0d c%0d", i, col_exp), ov, ev);
            end
            if (col_exp == stall_col && stalls > 0) begin
                out_ready = 1'b0;
                stalls--;
            end else begin
                out_ready = 1'b1;
                col_exp++;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        chk("drain_cycles", cycles, COL + ((stall_col >= 0) ? stall_n : 0));
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    task automatic run_pass(input int k_len, input int gap_mode, input int stall_col, input int stall_n);
        model(k_len);
        send_beats(k_len, gap_mode);
        finish_pass(stall_col, stall_n);
    endtask

    initial begin
        int kr;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // K=1, act=1, wgt=2
        for (int i = 0; i < ROW; i++) act_m[0][i] = 1;
        for (int j = 0; j < COL; j++) wgt_m[0][j] = 2;
        run_pass(1, 0, -1, 0);

        // K=4 identity activations; then the same with 1-0-1-0 bubbles
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ROW; i++) act_m[k][i] = (i == k) ? 1 : 0;
            for (int j = 0; j < COL; j++) wgt_m[k][j] = j + 1 + 4 * k;
        end
        run_pass(4, 0, -1, 0);
        run_pass(4, 1, -1, 0);

        // backpressure on column 1 for 3 cycles
        fill_rand(5, -128, 127);
        run_pass(5, 0, 1, 3);

        // overflow: 3 x (-128 * -128) exceeds 16-bit signed range
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ROW; i++) act_m[k][i] = -128;
            for (int j = 0; j < COL; j++) wgt_m[k][j] = -128;
        end
        run_pass(3, 0, -1, 0);

        // small operands: no overflow, sticky flag must have cleared
        fill_rand(4, -10, 10);
        run_pass(4, 2, -1, 0);

        for (int p = 0; p < 6; p++) begin
            kr = 1 + int'($urandom_range(0, 7));
            fill_rand(kr, -128, 127);
            run_pass(kr, 2, int'($urandom_range(0, 4)) - 1, 1 + int'($urandom_range(0, 2)));
        end

        // asynchronous reset while flushing
        fill_rand(3, -128, 127);
        send_beats(3, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_out_col", out_col, 0);
        chk("async_rst_out_last", out_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_out_valid", out_valid, 0);
        fill_rand(6, -128, 127);
        run_pass(6, 2, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
